crc_block_framer: RTL

//   Transmit side of the CRC_start/CRC_data/CRC_END bit-serial link into the turbo interleaver.

---
 rtl/crc_block_framer_if.sv | 13 +
 rtl/crc_block_framer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/crc_block_framer_if.sv
// rtl/crc_block_framer_if.sv - payload source handshake between upstream segmenter and framer
//   src_bit   : payload bit from upstream
//   src_valid : src_bit is valid
//   src_ready : framer consumes src_bit this cycle
//   master = upstream source, slave = framer
interface crc_block_framer_if;
  logic src_bit;
  logic src_valid;
  logic src_ready;

  modport master (output src_bit, output src_valid, input src_ready);
  modport slave  (input src_bit, input src_valid, output src_ready);
endinterface

// File: rtl/crc_block_framer.sv
// rtl/crc_block_framer.sv - bit-serial code-block framer appending a CRC-24B to K-24 payload bits
//   clk, reset       : clock (rising edge), asynchronous active-high reset
//   blk_start_i      : block request, sampled only in IDLE
//   blk_size_i       : 0 = K_SMALL, 1 = K_LARGE, sampled with blk_start_i
//   src_if (slave)   : payload bit source (src_bit/src_valid in, src_ready out)
//   crc_start_o      : one-cycle block-start pulse
//   crc_data_o       : serial block bit
//   crc_end_o        : high with the K-th bit
//   blk_size_o       : latched block size, held while busy
//   busy_o           : high from crc_start through the last gap cycle
//   underrun_err_o   : sticky missing-payload flag, cleared by the next accepted block
module crc_block_framer #(
  parameter int                 K_SMALL    = 1056,
  parameter int                 K_LARGE    = 6144,
  parameter int                 CRC_W      = 24,
  parameter logic [CRC_W-1:0]   CRC_POLY   = 24'h800063,
  parameter int                 GAP_CYCLES = 2,
  parameter int                 CNT_W      = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blk_start_i,
  input  logic                  blk_size_i,
  crc_block_framer_if.slave     src_if,
  output logic                  crc_start_o,
  output logic                  crc_data_o,
  output logic                  crc_end_o,
  output logic                  blk_size_o,
  output logic                  busy_o,
  output logic                  underrun_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_PAYLOAD, S_CRC, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             size_q, size_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             start_q, start_d;
  logic             data_q, data_d;
  logic             end_q, end_d;
  logic             size_o_q, size_o_d;
  logic             busy_q, busy_d;
  logic             under_q, under_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic             take;
  logic             in_bit;
  logic             fb;

  // Last PAYLOAD counter value: the payload phase lasts K-CRC_W cycles.
  logic [CNT_W-1:0] last_payload;
  assign last_payload = k_q - CNT_W'(CRC_W + 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (blk_start_i) state_d = S_START;
      S_START:   state_d = S_PAYLOAD;
      S_PAYLOAD: if (cnt_q == last_payload) state_d = S_CRC;
      S_CRC:     if (cnt_q == CNT_W'(CRC_W - 1)) state_d = S_GAP;
      S_GAP:     if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // The counter restarts at zero on every state change and idles at zero.
    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
  end

  always_comb begin
    accept = (state_q == S_IDLE) && blk_start_i;
    // src_ready is registered, so the consumption happens on the edge that ends a ready cycle.
    take   = ready_q;
    in_bit = src_if.src_valid & src_if.src_bit;
    fb     = crc_q[CRC_W-1] ^ in_bit;

    k_d    = k_q;
    size_d = size_q;
    if (accept) begin
      k_d    = blk_size_i ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL);
      size_d = blk_size_i;
    end

    crc_d = crc_q;
    if (accept)
      crc_d = '0;
    else if (take)
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    else if (state_d == S_CRC)
      crc_d = {crc_q[CRC_W-2:0], 1'b0};

    under_d = under_q;
    if (accept)
      under_d = 1'b0;
    else if (take && !src_if.src_valid)
      under_d = 1'b1;

    data_d = 1'b0;
    if (state_d == S_PAYLOAD)
      data_d = take & in_bit;
    else if (state_d == S_CRC)
      data_d = crc_q[CRC_W-1];

    start_d  = (state_d == S_START);
    end_d    = (state_d == S_CRC) && (cnt_d == CNT_W'(CRC_W - 1));
    busy_d   = (state_d != S_IDLE);
    size_o_d = (state_d != S_IDLE) & size_d;
    // Ready spans START plus all PAYLOAD cycles except the last one.
    ready_d  = (state_d == S_START) ||
               ((state_d == S_PAYLOAD) && (cnt_d != last_payload));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      k_q      <= '0;
      size_q   <= 1'b0;
      crc_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= 1'b0;
      end_q    <= 1'b0;
      size_o_q <= 1'b0;
      busy_q   <= 1'b0;
      under_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      size_q   <= size_d;
      crc_q    <= crc_d;
      start_q  <= start_d;
      data_q   <= data_d;
      end_q    <= end_d;
      size_o_q <= size_o_d;
      busy_q   <= busy_d;
      under_q  <= under_d;
      ready_q  <= ready_d;
    end
  end

  assign src_if.src_ready = ready_q;
  assign crc_start_o      = start_q;
  assign crc_data_o       = data_q;
  assign crc_end_o        = end_q;
  assign blk_size_o       = size_o_q;
  assign busy_o           = busy_q;
  assign underrun_err_o   = under_q;

endmodule
